// File: rtl/ser_pkg.sv
// Shared state encoding and sizing helper for the word serializer.
package ser_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Parallel word handshake plus serial frame outputs of the word serializer.
interface word_serializer_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_frame;
  logic             done;
  logic             busy;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  ser_out,
    input  ser_valid,
    input  ser_frame,
    input  done,
    input  busy
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output ser_out,
    output ser_valid,
    output ser_frame,
    output done,
    output busy
  );

endinterface

// File: rtl/ser_hold_buf.sv
// One-entry holding buffer; ready depends only on the registered full flag and reset.
module ser_hold_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_full,
  input  logic             pop
);

  logic [WIDTH-1:0] hold_q;
  logic             full_q;

  assign in_ready = ~full_q & ~rst;
  assign out_data = hold_q;
  assign out_full = full_q;

  // Accept and pop are mutually exclusive since in_ready is low while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      hold_q <= in_data;
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-in / serial-out frame transmitter: one bit every DIV cycles, back-to-back frames.
module word_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIV       = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  word_serializer_if.slave  bus
);

  localparam int unsigned BitCntW = clog2_min1(WIDTH);
  localparam int unsigned DivCntW = clog2_min1(DIV);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DivCntW-1:0] div_cnt_q, div_cnt_d;

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             pop;
  logic             div_last;
  logic             bit_last;
  logic [WIDTH-1:0] shifted;

  ser_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .in_data  (bus.s_data),
    .in_valid (bus.s_valid),
    .in_ready (bus.s_ready),
    .out_data (hold_data),
    .out_full (hold_full),
    .pop      (pop)
  );

  assign div_last = (div_cnt_q == DivCntW'(DIV - 1));
  assign bit_last = (bit_cnt_q == BitCntW'(WIDTH - 1));
  assign shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hold_full) begin
          shreg_d   = hold_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          pop       = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!div_last) begin
          div_cnt_d = div_cnt_q + DivCntW'(1);
        end else begin
          div_cnt_d = '0;
          if (!bit_last) begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
            shreg_d   = shifted;
          end else if (hold_full) begin
            // Back-to-back: next word starts with no idle cycle.
            shreg_d   = hold_data;
            bit_cnt_d = '0;
            pop       = 1'b1;
          end else begin
            shreg_d   = '0;
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q == ST_SHIFT);
    bus.ser_valid = (state_q == ST_SHIFT);
    bus.ser_out   = (state_q == ST_SHIFT) &
                    (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    bus.ser_frame = (state_q == ST_SHIFT) & (bit_cnt_q == '0);
    bus.done      = (state_q == ST_SHIFT) & bit_last & div_last;
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench: three serializer configurations driven from a vector table plus corner sequences.
module tb_word_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  word_serializer_if #(.WIDTH(8)) i0 ();
  word_serializer_if #(.WIDTH(8)) i1 ();
  word_serializer_if #(.WIDTH(8)) i2 ();

  word_serializer #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b0)) u0 (.clk(clk), .rst(rst), .bus(i0));
  word_serializer #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  word_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u2 (.clk(clk), .rst(rst), .bus(i2));

  logic [7:0] drv_data  [3];
  logic       drv_valid [3];
  logic [4:0] obs       [3];  // {ser_out, ser_valid, ser_frame, done, busy}
  logic       rdy       [3];

  assign i0.s_data = drv_data[0];
  assign i1.s_data = drv_data[1];
  assign i2.s_data = drv_data[2];
  assign i0.s_valid = drv_valid[0];
  assign i1.s_valid = drv_valid[1];
  assign i2.s_valid = drv_valid[2];
  assign obs[0] = {i0.ser_out, i0.ser_valid, i0.ser_frame, i0.done, i0.busy};
  assign obs[1] = {i1.ser_out, i1.ser_valid, i1.ser_frame, i1.done, i1.busy};
  assign obs[2] = {i2.ser_out, i2.ser_valid, i2.ser_frame, i2.done, i2.busy};
  assign rdy[0] = i0.s_ready;
  assign rdy[1] = i1.s_ready;
  assign rdy[2] = i2.s_ready;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         id;
    int         div;
    logic [7:0] data;
    logic [7:0] seq;  // seq[i] is the i-th bit on the wire
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input int id, input int div, input logic [7:0] data,
                           input logic [7:0] seq);
    @(negedge clk);
    check("ready_idle", {7'd0, rdy[id]}, 8'd1);
    drv_data[id]  = data;
    drv_valid[id] = 1'b1;
    @(negedge clk);
    drv_valid[id] = 1'b0;
    check("latency_gap", {3'd0, obs[id]}, 8'd0);
    check("ready_held", {7'd0, rdy[id]}, 8'd0);
    for (int c = 0; c < 8 * div; c++) begin
      @(negedge clk);
      check("frame_bit", {3'd0, obs[id]},
            {3'd0, seq[c / div], 1'b1, (c < div), (c == 8 * div - 1), 1'b1});
    end
    @(negedge clk);
    check("post_idle", {2'd0, rdy[id], obs[id]}, 8'h20);
  endtask

  task automatic back_to_back();
    @(negedge clk);
    drv_data[0]  = 8'h01;
    drv_valid[0] = 1'b1;
    @(negedge clk);
    drv_data[0]  = 8'h80;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      check("b2b_cycle", {2'd0, rdy[0], obs[0]},
            {2'd0, (c == 0) || (c >= 16), (c / 2 == 0) || (c / 2 == 15), 1'b1,
             (c < 2) || (c == 16) || (c == 17), (c == 15) || (c == 31), 1'b1});
      if (c == 1) drv_valid[0] = 1'b0;
    end
    @(negedge clk);
    check("b2b_end", {2'd0, rdy[0], obs[0]}, 8'h20);
  endtask

  task automatic reset_mid_frame();
    @(negedge clk);
    drv_data[0]  = 8'h01;
    drv_valid[0] = 1'b1;
    @(negedge clk);
    drv_data[0]  = 8'h80;
    @(negedge clk);
    @(negedge clk);
    drv_valid[0] = 1'b0;
    check("held_full", {7'd0, rdy[0]}, 8'd0);
    repeat (5) @(negedge clk);
    check("bit3_state", {3'd0, obs[0]}, 8'h09);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_outputs", {2'd0, rdy[0], obs[0]}, 8'h00);
    end
    rst = 1'b0;
    #1;
    check("rst_release_ready", {7'd0, rdy[0]}, 8'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("held_discarded", {2'd0, rdy[0], obs[0]}, 8'h20);
    end
    run_frame(0, 2, 8'hFF, 8'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{id: 0, div: 2, data: 8'hC1, seq: 8'hC1};
    vecs[1] = '{id: 1, div: 2, data: 8'hC1, seq: 8'h83};
    vecs[2] = '{id: 2, div: 1, data: 8'hAA, seq: 8'hAA};
    vecs[3] = '{id: 0, div: 2, data: 8'h5A, seq: 8'h5A};
    vecs[4] = '{id: 1, div: 2, data: 8'h01, seq: 8'h80};
    vecs[5] = '{id: 1, div: 2, data: 8'h5A, seq: 8'h5A};
    vecs[6] = '{id: 2, div: 1, data: 8'h0F, seq: 8'h0F};
    for (int i = 0; i < 3; i++) begin
      drv_data[i]  = 8'h00;
      drv_valid[i] = 1'b0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check("reset_state", {2'd0, rdy[i], obs[i]}, 8'h00);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check("reset_ready", {7'd0, rdy[i]}, 8'd1);

    for (int v = 0; v < 7; v++) run_frame(vecs[v].id, vecs[v].div, vecs[v].data, vecs[v].seq);

    back_to_back();
    reset_mid_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
